fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the word-addressed instruction memory. It owns the program counter, drives the memory's combinational read address, and registers the returned word into an IF/ID output slot. That slot uses a valid/ready handshake toward decode. The stage also handles branch/jump redirects, decode back-pressure, and misaligned or out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0004, PC loaded on reset; must be word-aligned.
IMEM_DEPTH, 128, number of 32-bit words in instruction memory; valid byte addresses are 0 .. 4*IMEM_DEPTH-4.
NOP_INST, 32'h0000_0013, value driven on if_inst whenever the slot is empty (addi x0,x0,0).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset.
pc_out  out  32  fetch address to instruction memory; combinational copy of pc_q.
inst_in  in  32  instruction word returned combinationally by memory for pc_out.
fetch_en  in  1  when 0, no new fetch is started; slot contents and handshake behave normally.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_target  in  32  new PC when redirect_valid=1.
if_valid  out  1  output slot holds a valid instruction.
if_ready  in  1  decode accepts the slot this cycle.
if_pc  out  32  PC of the instruction in the slot.
if_pc_plus4  out  32  if_pc+4, modulo 2^32.
if_inst  out  32  instruction in the slot.
fetch_fault  out  1  sticky fault indicator.
fault_pc  out  32  address that caused the fault.

Behaviour:
- Reset (rst_n=0 at edge):
  - pc_q=RESET_PC, if_valid=0, if_pc=0, if_inst=NOP_INST.
  - fetch_fault=0, fault_pc=0, state=RUN.
  - Reset takes priority over every other input, including mid-redirect and mid-stall.
- States: RUN and FAULT. The slot-full/slot-empty condition is tracked by if_valid, not by a separate state.
- Definitions:
  - slot_free = !if_valid || if_ready.
  - pc_ok = (pc_q[1:0]==0) && (pc_q[31:2] < IMEM_DEPTH).
- RUN, per edge, first matching rule wins:
  1. redirect_valid=1 with a misaligned or out-of-range target:
     - go to FAULT; fault_pc=target; if_valid=0.
  2. redirect_valid=1 with a good target:
     - pc_q=target; if_valid=0 (flush); if_inst=NOP_INST.
     - No capture that cycle (one bubble).
  3. fetch_en && slot_free && !pc_ok:
     - go to FAULT; fault_pc=pc_q; if_valid=0.
  4. fetch_en && slot_free:
     - capture: if_inst=inst_in, if_pc=pc_q, if_valid=1, pc_q=pc_q+4.
  5. slot_free && !fetch_en:
     - if_valid=0, if_inst=NOP_INST, pc_q unchanged.
  6. Otherwise (stall):
     - hold all registers.
     - if_pc, if_inst and if_pc_plus4 stay bit-stable while if_valid && !if_ready.
- FAULT:
  - fetch_fault=1; if_valid=0; pc_q frozen; no captures.
  - Exit only by reset, or by redirect_valid with a good target. That exit loads pc_q, clears fetch_fault, and returns to RUN.
  - A redirect with a bad target while already in FAULT updates fault_pc only.
- Latency:
  - The word at PC A is presented on if_inst on the edge after pc_out=A.
  - Back-to-back throughput is 1 instruction/cycle with if_ready=1.
  - After a redirect, the target's instruction is valid 2 edges after redirect_valid is sampled.
- Arithmetic: PC increment is 32-bit modulo 2^32 with no wrap special case; the range check catches overflow.
- A redirect in the same cycle as a decode accept: the accept completes (decode consumed the old slot) and the redirect flushes and reloads as in rule 2.
- pc_out is always driven (=pc_q), including in FAULT and during stall. Memory reads have no side effects.

Decomposition:
- Shared package fetch_pkg:
  - NOP_INST constant.
  - Default RESET_PC.
  - fetch_state_t enum {RUN, FAULT}.
  - Function pc_in_range(addr, depth).
- One natural sub-module: fetch_pc_gen. It holds the combinational next-PC mux (redirect/+4/hold) plus the alignment and range check, and is instantiated once inside fetch_unit.

Test Plan:
- Reset then fetch_en=1, if_ready=1, memory words 4→0x00430820, 8→0x00851022, 12→0x3C071064 -> if_pc 4,8,12 on consecutive cycles with matching if_inst; if_pc_plus4 = 8,12,16.
- Stall: if_ready=0 for 3 cycles while if_pc=8 -> if_pc/if_inst held at 8/0x00851022; pc_out stays 12; after release, next capture is PC 12 with no duplicate or skip.
- Redirect to 0x40 while slot holds PC 8 -> next edge if_valid=0; following edge if_valid=1, if_pc=0x40; PC 12 never presented.
- Redirect to 0x42 -> fetch_fault=1, fault_pc=0x42, if_valid=0; later redirect to 0x10 -> fault cleared, if_pc=0x10 two edges later.
- Sequential run from 0x1F8 with IMEM_DEPTH=128 -> PCs 0x1F8, 0x1FC delivered; fetch at 0x200 raises fetch_fault with fault_pc=0x200.
- Assert rst_n=0 during a stall with fetch_fault=0 -> next edge pc_out=4, if_valid=0, if_inst=0x00000013.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   NOP_INST          : word presented on if_inst whenever the IF/ID slot is empty
//   DEFAULT_RESET_PC  : default program counter after reset
//   DEFAULT_IMEM_DEPTH: default instruction memory size in 32-bit words
//   fetch_state_t     : RUN / FAULT control state
//   pc_in_range()     : word index of a byte address lies inside the memory
package fetch_pkg;

    localparam logic [31:0] NOP_INST           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0004;
    localparam int unsigned DEFAULT_IMEM_DEPTH = 128;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // Only the word index is examined; alignment is checked separately.
    function automatic logic pc_in_range(input logic [31:0] addr, input int unsigned depth);
        return ({2'b00, addr[31:2]} < depth);
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and address legality checks for the fetch stage.
//   pc_i        : current program counter
//   redirect_i  : branch/jump redirect request
//   target_i    : redirect destination
//   advance_i   : an instruction is captured this cycle, step PC by 4
//   pc_next_o   : next program counter
//   pc_ok_o     : current PC is word-aligned and inside instruction memory
//   target_ok_o : redirect target is word-aligned and inside instruction memory
import fetch_pkg::*;

module fetch_pc_gen #(
    parameter int unsigned IMEM_DEPTH = DEFAULT_IMEM_DEPTH
) (
    input  logic [31:0] pc_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        advance_i,
    output logic [31:0] pc_next_o,
    output logic        pc_ok_o,
    output logic        target_ok_o
);

    assign pc_ok_o     = (pc_i[1:0] == 2'b00)     && pc_in_range(pc_i, IMEM_DEPTH);
    assign target_ok_o = (target_i[1:0] == 2'b00) && pc_in_range(target_i, IMEM_DEPTH);

    // A bad redirect target never reaches the PC: it only records a fault.
    // The +4 wraps modulo 2^32; the range check turns any wrap into a fault.
    always_comb begin
        pc_next_o = pc_i;
        if (redirect_i && target_ok_o) begin
            pc_next_o = target_i;
        end else if (advance_i) begin
            pc_next_o = pc_i + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction memory
// combinationally and registers the returned word into an IF/ID slot with a
// valid/ready handshake toward decode.
//   clk, rst_n            : clock, synchronous active-low reset
//   pc_out / inst_in      : memory address out, instruction word back (same cycle)
//   fetch_en              : permit new fetches
//   redirect_valid/target : branch/jump redirect (flushes the slot)
//   if_valid/if_ready     : slot handshake toward decode
//   if_pc/if_pc_plus4/if_inst : slot contents
//   fetch_fault/fault_pc  : sticky fault flag and offending address
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC   = fetch_pkg::DEFAULT_RESET_PC,
    parameter int unsigned IMEM_DEPTH = fetch_pkg::DEFAULT_IMEM_DEPTH,
    parameter logic [31:0] NOP_INST   = fetch_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_in,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_inst,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic slot_free;
    logic advance;
    logic pc_ok;
    logic target_ok;

    assign slot_free = !valid_q || if_ready;

    fetch_pc_gen #(
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_pc_gen (
        .pc_i        (pc_q),
        .redirect_i  (redirect_valid),
        .target_i    (redirect_target),
        .advance_i   (advance),
        .pc_next_o   (pc_d),
        .pc_ok_o     (pc_ok),
        .target_ok_o (target_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'd0;
            inst_q     <= NOP_INST;
            fault_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            inst_q     <= inst_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // Every path that empties the slot also reloads NOP so if_inst shows NOP
    // whenever if_valid is low. A stall falls through with everything held.
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        if_pc_d    = if_pc_q;
        inst_d     = inst_q;
        fault_pc_d = fault_pc_q;
        advance    = 1'b0;

        case (state_q)
            RUN: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                    if (!target_ok) begin
                        state_d    = FAULT;
                        fault_pc_d = redirect_target;
                    end
                end else if (fetch_en && slot_free) begin
                    if (!pc_ok) begin
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                        valid_d    = 1'b0;
                        inst_d     = NOP_INST;
                    end else begin
                        advance = 1'b1;
                        valid_d = 1'b1;
                        if_pc_d = pc_q;
                        inst_d  = inst_in;
                    end
                end else if (slot_free) begin
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                end
            end
            FAULT: begin
                valid_d = 1'b0;
                inst_d  = NOP_INST;
                if (redirect_valid) begin
                    if (target_ok) begin
                        state_d = RUN;
                    end else begin
                        fault_pc_d = redirect_target;
                    end
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign pc_out      = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc_q + 32'd4;
    assign if_inst     = inst_q;
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] inst_in;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_inst;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    logic [31:0] mem [0:255];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign inst_in = mem[pc_out[9:2]];

    fetch_unit #(
        .RESET_PC   (32'h0000_0004),
        .IMEM_DEPTH (128),
        .NOP_INST   (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .pc_out          (pc_out),
        .inst_in         (inst_in),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_inst         (if_inst),
        .fetch_fault     (fetch_fault),
        .fault_pc        (fault_pc)
    );

    // ---------------- reference model (architectural view) ----------------
    logic [31:0] m_pc, m_ifpc, m_inst, m_fpc;
    logic        m_valid, m_fault;
    logic [31:0] n_pc, n_ifpc, n_inst, n_fpc;
    logic        n_valid, n_fault;

    function automatic bit addr_good(input logic [31:0] a);
        return ((a % 4) == 0) && ((a / 4) < 128);
    endfunction

    // Next architectural state from the current one and the present inputs.
    task automatic model_next();
        n_pc = m_pc; n_ifpc = m_ifpc; n_inst = m_inst;
        n_fpc = m_fpc; n_valid = m_valid; n_fault = m_fault;
        if (!rst_n) begin
            n_pc = 32'h4; n_ifpc = 0; n_inst = NOP; n_fpc = 0; n_valid = 0; n_fault = 0;
        end else if (m_fault) begin
            n_valid = 0; n_inst = NOP;
            if (redirect_valid) begin
                if (addr_good(redirect_target)) begin
                    n_pc = redirect_target; n_fault = 0;
                end else begin
                    n_fpc = redirect_target;
                end
            end
        end else if (redirect_valid) begin
            n_valid = 0; n_inst = NOP;
            if (addr_good(redirect_target)) n_pc = redirect_target;
            else begin n_fault = 1; n_fpc = redirect_target; end
        end else if (fetch_en && (!m_valid || if_ready)) begin
            if (!addr_good(m_pc)) begin
                n_fault = 1; n_fpc = m_pc; n_valid = 0; n_inst = NOP;
            end else begin
                n_valid = 1; n_ifpc = m_pc; n_inst = mem[m_pc[9:2]]; n_pc = m_pc + 32'd4;
            end
        end else if (!m_valid || if_ready) begin
            n_valid = 0; n_inst = NOP;
        end
    endtask

    task automatic tick_model();
        model_next();
        @(posedge clk); #1;
        m_pc = n_pc; m_ifpc = n_ifpc; m_inst = n_inst;
        m_fpc = n_fpc; m_valid = n_valid; m_fault = n_fault;
    endtask

    task automatic apply_reset();
        rst_n = 0; fetch_en = 0; if_ready = 1; redirect_valid = 0; redirect_target = 0;
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        rst_n = 0; fetch_en = 1; if_ready = 0; redirect_valid = 1; redirect_target = 32'h80;
        @(posedge clk); #1;
        checks++;
        if (pc_out !== 32'h4 || if_valid !== 1'b0 || if_pc !== 32'h0 || if_inst !== NOP ||
            fetch_fault !== 1'b0 || fault_pc !== 32'h0 || if_pc_plus4 !== 32'h4) begin
            errors++;
            $display("FAIL reset: pc_out=%h valid=%b if_pc=%h inst=%h fault=%b fpc=%h plus4=%h, want 4/0/0/13/0/0/4",
                     pc_out, if_valid, if_pc, if_inst, fetch_fault, fault_pc, if_pc_plus4);
        end
        $display("reset: pc_out=%h if_valid=%b if_inst=%h", pc_out, if_valid, if_inst);
        rst_n = 1; redirect_valid = 0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_inst [3];
        exp_pc   = '{32'h4, 32'h8, 32'hC};
        exp_inst = '{32'h0043_0820, 32'h0085_1022, 32'h3C07_1064};
        apply_reset();
        fetch_en = 1; if_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || if_inst !== exp_inst[i] ||
                if_pc_plus4 !== exp_pc[i] + 32'd4) begin
                errors++;
                $display("FAIL seq[%0d]: valid=%b pc=%h inst=%h plus4=%h, want 1/%h/%h/%h",
                         i, if_valid, if_pc, if_inst, if_pc_plus4, exp_pc[i], exp_inst[i], exp_pc[i] + 32'd4);
            end
            $display("seq: if_pc=%h if_inst=%h if_pc_plus4=%h", if_pc, if_inst, if_pc_plus4);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        fetch_en = 1; if_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'h0085_1022 ||
                if_pc_plus4 !== 32'hC || pc_out !== 32'hC) begin
                errors++;
                $display("FAIL stall[%0d]: valid=%b pc=%h inst=%h plus4=%h pc_out=%h, want 1/8/00851022/c/c",
                         i, if_valid, if_pc, if_inst, if_pc_plus4, pc_out);
            end
            $display("stall: if_pc=%h if_inst=%h pc_out=%h", if_pc, if_inst, pc_out);
        end
        if_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'hC || if_inst !== 32'h3C07_1064) begin
            errors++;
            $display("FAIL stall_release: valid=%b pc=%h inst=%h, want 1/c/3c071064", if_valid, if_pc, if_inst);
        end
        $display("stall release: if_pc=%h if_inst=%h", if_pc, if_inst);
    endtask

    task automatic test_redirect();
        apply_reset();
        fetch_en = 1; if_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        redirect_valid = 1; redirect_target = 32'h40;
        @(posedge clk); #1;
        redirect_valid = 0;
        checks++;
        if (if_valid !== 1'b0 || pc_out !== 32'h40 || if_inst !== NOP) begin
            errors++;
            $display("FAIL redirect_flush: valid=%b pc_out=%h inst=%h, want 0/40/13", if_valid, pc_out, if_inst);
        end
        $display("redirect flush: if_valid=%b pc_out=%h", if_valid, pc_out);
        @(posedge clk); #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== mem[16]) begin
            errors++;
            $display("FAIL redirect_target: valid=%b pc=%h inst=%h, want 1/40/%h", if_valid, if_pc, if_inst, mem[16]);
        end
        $display("redirect target: if_pc=%h if_inst=%h", if_pc, if_inst);
    endtask

    task automatic test_fault_redirect();
        apply_reset();
        fetch_en = 1; if_ready = 1;
        redirect_valid = 1; redirect_target = 32'h42;
        @(posedge clk); #1;
        redirect_valid = 0;
        checks++;
        if (fetch_fault !== 1'b1 || fault_pc !== 32'h42 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL fault_entry: fault=%b fpc=%h valid=%b, want 1/42/0", fetch_fault, fault_pc, if_valid);
        end
        $display("fault entry: fetch_fault=%b fault_pc=%h", fetch_fault, fault_pc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (fetch_fault !== 1'b1 || pc_out !== 32'h4 || if_valid !== 1'b0 || if_inst !== NOP) begin
            errors++;
            $display("FAIL fault_hold: fault=%b pc_out=%h valid=%b inst=%h, want 1/4/0/13",
                     fetch_fault, pc_out, if_valid, if_inst);
        end
        $display("fault hold: pc_out=%h", pc_out);
        redirect_valid = 1; redirect_target = 32'h1000;
        @(posedge clk); #1;
        checks++;
        if (fetch_fault !== 1'b1 || fault_pc !== 32'h1000 || pc_out !== 32'h4) begin
            errors++;
            $display("FAIL fault_rebad: fault=%b fpc=%h pc_out=%h, want 1/1000/4", fetch_fault, fault_pc, pc_out);
        end
        $display("fault bad redirect: fault_pc=%h", fault_pc);
        redirect_target = 32'h10;
        @(posedge clk); #1;
        redirect_valid = 0;
        checks++;
        if (fetch_fault !== 1'b0 || if_valid !== 1'b0 || pc_out !== 32'h10) begin
            errors++;
            $display("FAIL fault_exit: fault=%b valid=%b pc_out=%h, want 0/0/10", fetch_fault, if_valid, pc_out);
        end
        $display("fault exit: fetch_fault=%b pc_out=%h", fetch_fault, pc_out);
        @(posedge clk); #1;
        checks++;
        if (if_valid !== 1'b1 || if_pc !== 32'h10 || if_inst !== mem[4]) begin
            errors++;
            $display("FAIL fault_resume: valid=%b pc=%h inst=%h, want 1/10/%h", if_valid, if_pc, if_inst, mem[4]);
        end
        $display("fault resume: if_pc=%h", if_pc);
    endtask

    task automatic test_range_end();
        logic [31:0] exp_pc [2];
        exp_pc = '{32'h1F8, 32'h1FC};
        apply_reset();
        fetch_en = 1; if_ready = 1;
        redirect_valid = 1; redirect_target = 32'h1F8;
        @(posedge clk); #1;
        redirect_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if_valid !== 1'b1 || if_pc !== exp_pc[i] || fetch_fault !== 1'b0) begin
                errors++;
                $display("FAIL range_end[%0d]: valid=%b pc=%h fault=%b, want 1/%h/0",
                         i, if_valid, if_pc, fetch_fault, exp_pc[i]);
            end
            $display("range end: if_pc=%h", if_pc);
        end
        @(posedge clk); #1;
        checks++;
        if (fetch_fault !== 1'b1 || fault_pc !== 32'h200 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_fault: fault=%b fpc=%h valid=%b, want 1/200/0", fetch_fault, fault_pc, if_valid);
        end
        $display("range fault: fault_pc=%h", fault_pc);
    endtask

    task automatic test_reset_in_stall();
        apply_reset();
        fetch_en = 1; if_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if_ready = 0;
        @(posedge clk); #1;
        rst_n = 0; redirect_valid = 1; redirect_target = 32'h80;
        @(posedge clk); #1;
        rst_n = 1; redirect_valid = 0;
        checks++;
        if (pc_out !== 32'h4 || if_valid !== 1'b0 || if_inst !== NOP || if_pc !== 32'h0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: pc_out=%h valid=%b inst=%h if_pc=%h fault=%b, want 4/0/13/0/0",
                     pc_out, if_valid, if_inst, if_pc, fetch_fault);
        end
        $display("reset in stall: pc_out=%h if_valid=%b", pc_out, if_valid);
        if_ready = 1;
    endtask

    // ---------------- randomized test against the model ----------------
    task automatic test_random();
        int mism;
        mism = 0;
        rst_n = 0; fetch_en = 0; if_ready = 1; redirect_valid = 0; redirect_target = 0;
        tick_model();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n          = ($urandom_range(0, 199) != 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            if_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 3))
                0: redirect_target = 32'($urandom_range(0, 127)) << 2;
                1: redirect_target = 32'h1F0 + (32'($urandom_range(0, 3)) << 2);
                2: redirect_target = (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3));
                default: redirect_target = $urandom;
            endcase
            tick_model();
            checks++;
            if (pc_out !== m_pc) begin
                errors++; mism++;
                $display("FAIL rand_pc_out cyc=%0d: got %h want %h", cyc, pc_out, m_pc);
            end
            checks++;
            if (if_valid !== m_valid) begin
                errors++; mism++;
                $display("FAIL rand_valid cyc=%0d: got %b want %b", cyc, if_valid, m_valid);
            end
            checks++;
            if (if_pc !== m_ifpc) begin
                errors++; mism++;
                $display("FAIL rand_if_pc cyc=%0d: got %h want %h", cyc, if_pc, m_ifpc);
            end
            checks++;
            if (if_pc_plus4 !== m_ifpc + 32'd4) begin
                errors++; mism++;
                $display("FAIL rand_plus4 cyc=%0d: got %h want %h", cyc, if_pc_plus4, m_ifpc + 32'd4);
            end
            checks++;
            if (if_inst !== m_inst) begin
                errors++; mism++;
                $display("FAIL rand_inst cyc=%0d: got %h want %h", cyc, if_inst, m_inst);
            end
            checks++;
            if (fetch_fault !== m_fault) begin
                errors++; mism++;
                $display("FAIL rand_fault cyc=%0d: got %b want %b", cyc, fetch_fault, m_fault);
            end
            checks++;
            if (fault_pc !== m_fpc) begin
                errors++; mism++;
                $display("FAIL rand_fault_pc cyc=%0d: got %h want %h", cyc, fault_pc, m_fpc);
            end
            if (mism > 20) begin
                $display("random: stopping early after %0d discrepancies", mism);
                break;
            end
        end
        $display("random: 3000-cycle run done, discrepancies=%0d", mism);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[1] = 32'h0043_0820;
        mem[2] = 32'h0085_1022;
        mem[3] = 32'h3C07_1064;
        rst_n = 0; fetch_en = 0; if_ready = 1; redirect_valid = 0; redirect_target = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault_redirect();
        test_range_end();
        test_reset_in_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
